// File: rtl/scope_capture_ctrl.sv
// ----------------------------------------------------------------------------
// scope_capture_ctrl
//
// Capture sequencer for the scope path, pixel clock domain. Streams ADC
// samples into one bank of an external dual-bank sample RAM while the display
// reads the other bank. Keeps pre-trigger history, detects a rising/falling
// level crossing, supports normal/auto/single/stop modes, and hands a finished
// capture to the display only on a frame boundary.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   sample_valid, sample qualified 8-bit unsigned ADC sample
//   trig_level           trigger threshold (latched when a capture starts)
//   trig_rising          1 = rising edge, 0 = falling (latched at start)
//   pretrig              samples kept ahead of the trigger (latched at start)
//   mode                 0 normal, 1 auto, 2 single, 3 stop
//   arm                  pulse; starts one capture in single mode
//   frame_start          pulse at the start of each display frame
//   wr_en/wr_addr/wr_data RAM write port, wr_addr = {bank, pointer}
//   rd_bank, rd_base     bank the display reads and its oldest sample address
//   frame_valid          a capture has been published since reset
//   forced               published capture was auto-forced
//   state                IDLE=0, PREFILL=1, ARMED=2, POST=3, DONE=4
// ----------------------------------------------------------------------------
module scope_capture_ctrl #(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned AUTO_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [7:0]        sample,
    input  logic [7:0]        trig_level,
    input  logic              trig_rising,
    input  logic [ADDR_W-1:0] pretrig,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic              frame_start,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_base,
    output logic              frame_valid,
    output logic              forced,
    output logic [2:0]        state
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned TO_W  = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(AUTO_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPrefill = 3'd1,
        StArmed   = 3'd2,
        StPost    = 3'd3,
        StDone    = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;         // prefill count, then post count
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;   // valid samples seen in ARMED
    logic [7:0]        prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic [7:0]        level_q, level_d;
    logic              rising_q, rising_d;
    logic [ADDR_W-1:0] pretrig_q, pretrig_d;
    logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
    logic              forced_pend_q, forced_pend_d;
    logic              was_done_q;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic              frame_valid_q, frame_valid_d;
    logic              forced_q, forced_d;

    logic              accept;
    logic              real_trig;
    logic              timeout_hit;
    logic              publish;
    logic              start;
    logic [ADDR_W-1:0] post_len;

    assign accept = sample_valid &&
                    (state_q == StPrefill || state_q == StArmed || state_q == StPost);

    assign real_trig = (state_q == StArmed) && sample_valid && prev_valid_q &&
                       (rising_q ? (prev_q < level_q && sample >= level_q)
                                 : (prev_q > level_q && sample <= level_q));

    assign timeout_hit = (state_q == StArmed) && sample_valid && (mode == 2'd1) &&
                         (to_cnt_q == TO_LAST);

    // Frame_start on the very first DONE cycle is ignored so the final write
    // has landed before the display switches banks.
    assign publish = (state_q == StDone) && was_done_q && frame_start;

    assign start    = (mode == 2'd0) || (mode == 2'd1) || (mode == 2'd2 && arm);
    assign post_len = ADDR_W'(DEPTH - 1) - pretrig_q;

    always_comb begin
        state_d       = state_q;
        wr_bank_d     = wr_bank_q;
        wr_ptr_d      = wr_ptr_q;
        cnt_d         = cnt_q;
        to_cnt_d      = to_cnt_q;
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        level_d       = level_q;
        rising_d      = rising_q;
        pretrig_d     = pretrig_q;
        trig_ptr_d    = trig_ptr_q;
        forced_pend_d = forced_pend_q;
        rd_bank_d     = rd_bank_q;
        rd_base_d     = rd_base_q;
        frame_valid_d = frame_valid_q;
        forced_d      = forced_q;
        wr_en_d       = accept;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;

        if (accept) begin
            wr_addr_d    = {wr_bank_q, wr_ptr_q};
            wr_data_d    = sample;
            wr_ptr_d     = wr_ptr_q + ONE;
            prev_d       = sample;
            prev_valid_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    level_d       = trig_level;
                    rising_d      = trig_rising;
                    pretrig_d     = pretrig;
                    cnt_d         = '0;
                    to_cnt_d      = '0;
                    wr_ptr_d      = '0;
                    prev_valid_d  = 1'b0;
                    forced_pend_d = 1'b0;
                    state_d       = (pretrig == '0) ? StArmed : StPrefill;
                end
            end
            StPrefill: begin
                if (sample_valid) begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == pretrig_q - ONE) begin
                        state_d = StArmed;
                    end
                end
            end
            StArmed: begin
                if (sample_valid) begin
                    // Saturate so a long normal-mode wait cannot wrap around.
                    if (to_cnt_q != TO_LAST) begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                    if (real_trig || timeout_hit) begin
                        trig_ptr_d    = wr_ptr_q;
                        forced_pend_d = !real_trig;
                        cnt_d         = '0;
                        state_d       = (post_len == '0) ? StDone : StPost;
                    end
                end
            end
            StPost: begin
                if (sample_valid) begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == post_len - ONE) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (publish) begin
                    rd_bank_d     = wr_bank_q;
                    rd_base_d     = trig_ptr_q - pretrig_q;
                    forced_d      = forced_pend_q;
                    frame_valid_d = 1'b1;
                    wr_bank_d     = !wr_bank_q;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Stop discards any capture in progress; a finished one still publishes.
        if (mode == 2'd3 && state_q != StDone) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            wr_bank_q     <= 1'b1;
            wr_ptr_q      <= '0;
            cnt_q         <= '0;
            to_cnt_q      <= '0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            level_q       <= '0;
            rising_q      <= 1'b0;
            pretrig_q     <= '0;
            trig_ptr_q    <= '0;
            forced_pend_q <= 1'b0;
            was_done_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_bank_q     <= 1'b0;
            rd_base_q     <= '0;
            frame_valid_q <= 1'b0;
            forced_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            to_cnt_q      <= to_cnt_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            level_q       <= level_d;
            rising_q      <= rising_d;
            pretrig_q     <= pretrig_d;
            trig_ptr_q    <= trig_ptr_d;
            forced_pend_q <= forced_pend_d;
            was_done_q    <= (state_q == StDone);
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            rd_bank_q     <= rd_bank_d;
            rd_base_q     <= rd_base_d;
            frame_valid_q <= frame_valid_d;
            forced_q      <= forced_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_bank     = rd_bank_q;
    assign rd_base     = rd_base_q;
    assign frame_valid = frame_valid_q;
    assign forced      = forced_q;
    assign state       = state_q;

endmodule

// File: doc/scope_capture_ctrl.md
Name: scope_capture_ctrl

Overview:
- Capture sequencer for the scope path. Runs in the pixel clock domain.
- Writes incoming ADC samples into an external dual-bank sample RAM, with pre-trigger history, a trigger detector and auto/normal/single modes.
- Publishes a completed capture to the display reader only at frame boundaries, so the VGA renderer never shows a half-written trace.
- Arbitrates bank ownership between capture (writer) and display (reader).

Parameters:
ADDR_W, 9, log2 samples per bank; DEPTH = 2^ADDR_W
AUTO_TIMEOUT, 4096, valid samples in ARMED before auto mode forces a trigger (>=1)

Ports:
clk  in  1  pixel clock; single clock for the whole block
reset  in  1  synchronous, active-high
sample_valid  in  1  qualifies sample this cycle
sample  in  8  unsigned ADC sample
trig_level  in  8  trigger threshold; latched on IDLE->PREFILL
trig_rising  in  1  1 = rising edge, 0 = falling; latched on IDLE->PREFILL
pretrig  in  ADDR_W  samples kept before trigger; latched on IDLE->PREFILL
mode  in  2  0 normal, 1 auto, 2 single, 3 stop
arm  in  1  single-cycle pulse; starts one capture in single mode
frame_start  in  1  single-cycle pulse at start of each display frame
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W+1  {bank, pointer}
wr_data  out  8  sample to write
rd_bank  out  1  bank the display must read
rd_base  out  ADDR_W  address of oldest displayed sample in rd_bank
frame_valid  out  1  at least one capture published since reset
forced  out  1  published capture was auto-forced, not triggered
state  out  3  IDLE=0, PREFILL=1, ARMED=2, POST=3, DONE=4

Behaviour:
Reset:
- state=IDLE; wr_en=0; wr_addr=0; wr_data=0; rd_bank=0; rd_base=0; frame_valid=0; forced=0.
- wr_bank=1, so the first capture goes to bank 1. wr_ptr=0. prev_valid=0.
- Reset mid-capture aborts the capture. No publish occurs.

Write path:
- A valid sample in PREFILL, ARMED or POST on cycle N gives wr_en=1, wr_addr={wr_bank, wr_ptr}, wr_data=sample on cycle N+1.
- wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Samples in IDLE or DONE are dropped (wr_en=0).

Trigger detect (ARMED only, on valid samples):
- prev holds the last valid sample. prev_valid=0 after entering PREFILL; prev_valid=1 after the first valid sample.
- Rising: prev_valid && prev < level && sample >= level.
- Falling: prev_valid && prev > level && sample <= level.
- The trigger sample is itself written. trig_ptr = the wr_ptr used for it.

FSM:
- IDLE -> PREFILL:
  - Mode 0 or 1: next cycle.
  - Mode 2: on arm.
  - Mode 3: never.
  - On this transition, latch trig_level, trig_rising, pretrig; clear counters and prev_valid.
- PREFILL -> ARMED: after pretrig valid samples written. pretrig=0 goes straight to ARMED.
- ARMED -> POST: on trigger.
  - Auto mode: at the AUTO_TIMEOUT-th valid sample without a trigger, that sample is a forced trigger (forced_pending=1).
  - Timeout counter counts only in ARMED.
- POST -> DONE: after DEPTH-1-pretrig further valid samples. If that count is 0, go directly ARMED -> DONE.
- DONE -> publish: on the first frame_start strictly after the cycle DONE was entered:
  - rd_bank <= wr_bank.
  - rd_base <= (trig_ptr - pretrig) mod DEPTH.
  - forced <= forced_pending.
  - frame_valid <= 1.
  - wr_bank toggles.
  - Next state: IDLE.
- Mode 3 in any state except DONE: next state IDLE, capture discarded. In DONE, the publish still completes, then the FSM stays in IDLE.
- frame_start arriving in a non-DONE state: ignored.
- rd_bank, rd_base and forced change only on the publish cycle. The writer never addresses rd_bank.

Simultaneous events:
- arm outside IDLE: ignored.
- Trigger and timeout on the same sample: counts as a real trigger (forced_pending=0).

Test Plan:
- ADDR_W=4, mode 0, level 0x80 rising, pretrig 4, samples ramp 0x00,0x10,...; trigger at sample 0x80 written at ptr 8.
  - Required: post count 11; DONE after ptr 3 (wrapped).
  - At next frame_start: rd_bank=1, rd_base=4, frame_valid=1, forced=0, state=IDLE.
- Same setup, frame_start in the same cycle DONE is entered.
  - Required: no publish that cycle; publish on the following frame_start.
- Mode 1, AUTO_TIMEOUT=8, constant 0x20 samples.
  - Required: forced trigger on 8th ARMED sample; after publish forced=1.
  - Second capture writes bank 0; rd_bank stays 1 until its publish.
- Mode 2: no capture without arm.
  - After arm: one capture, one publish, then state stays IDLE.
  - arm pulsed mid-capture: no effect.
- Reset asserted in POST.
  - Required: next cycle state=0, wr_en=0, rd_bank=0, frame_valid=0.
  - Capture restarts in bank 1 from ptr 0.
- Falling edge, level 0x40, pretrig 0.
  - First sample after PREFILL = 0x30: must not trigger (prev invalid).
  - Sequence 0x50,0x40: triggers on 0x40.
  - post count 15; rd_base = trig_ptr.
